// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Instruction fetch front end. Holds a word-aligned fetch address
//             register, issues one outstanding memory read at a time, guards
//             against response timeouts, discards responses made obsolete by
//             an address change, and keeps a single-entry instruction buffer.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   clock, all state changes on rising edge
//    reset           in   1   synchronous, active-low reset
//    address_reg_sel in   2   next address: 00 ALU, 01 PC, 10 INC, 11 hold
//    update_address  in   1   load the address register this cycle
//    alu_result      in  32   branch / load target address
//    pc_value        in  32   R15 read value
//    fetch_en        in   1   permit new memory requests
//    instr_ack       in   1   consumer takes the buffered instruction
//    mem_req_ready   in   1   memory accepts the request
//    mem_rvalid      in   1   read response valid
//    mem_rdata       in  32   read response data
//    mem_req         out  1   read request
//    mem_addr        out 32   read request address
//    inc_address     out 32   address register + 4
//    instruction     out 32   buffered instruction word
//    instr_valid     out  1   buffer holds a valid instruction
//    fetch_abort     out  1   one-cycle pulse on response timeout
// ============================================================================
module instr_fetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address_reg_sel,
    input  logic        update_address,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_value,
    input  logic        fetch_en,
    input  logic        instr_ack,
    input  logic        mem_req_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] inc_address,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        fetch_abort
);

    localparam int          c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [31:0] c_NOP   = 32'hE1A0_0000;   // MOV R0,R0

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_REQ   = 2'd1;
    localparam logic [1:0]  c_WAIT  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [31:0]        r_addr;
    logic [31:0]        w_addr_next;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_instr;
    logic               r_valid;
    logic               r_need;
    logic               r_stale;
    logic               r_abort;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_start;
    logic               w_accept;
    logic               w_resp;
    logic               w_timeout;
    logic               w_fresh;

    // r_addr is always word aligned, so the increment stays aligned and wraps.
    assign inc_address = r_addr + 32'd4;

    always_comb begin
        w_addr_next = r_addr;
        case (address_reg_sel)
            2'b00:   w_addr_next = alu_result & ~32'h3;
            2'b01:   w_addr_next = pc_value & ~32'h3;
            2'b10:   w_addr_next = inc_address;
            default: w_addr_next = r_addr;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_resp       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (fetch_en && r_need && (!r_valid || instr_ack)) begin
                    w_state_next = c_REQ;
                    w_start      = 1'b1;
                end
            end
            c_REQ: begin
                if (mem_req_ready) begin
                    w_state_next = c_WAIT;
                    w_accept     = 1'b1;
                end
            end
            c_WAIT: begin
                if (mem_rvalid) begin
                    w_state_next = c_IDLE;
                    w_resp       = 1'b1;
                end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                    w_state_next = c_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // An address change in the same cycle as the response also obsoletes it:
    // the consumer has already moved on to the new address.
    assign w_fresh = w_resp && !r_stale && !update_address;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr     <= 32'd0;
            r_mem_addr <= 32'd0;
            r_instr    <= c_NOP;
            r_valid    <= 1'b0;
            r_need     <= 1'b1;
            r_stale    <= 1'b0;
            r_abort    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (update_address) begin
                r_addr <= w_addr_next;
            end

            // A new address always demands a fetch, even if it lands on the
            // cycle the current request is accepted.
            if (update_address || w_timeout) begin
                r_need <= 1'b1;
            end else if (w_accept) begin
                r_need <= 1'b0;
            end

            // The request address is frozen at REQ entry; an address update on
            // that very edge makes the issued request stale from the start.
            if (w_start) begin
                r_mem_addr <= r_addr;
                r_stale    <= update_address;
            end else if (update_address && (r_state != c_IDLE)) begin
                r_stale    <= 1'b1;
            end

            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == c_WAIT) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            r_abort <= w_timeout;

            if (w_fresh) begin
                r_instr <= mem_rdata;
                r_valid <= 1'b1;
            end else if (instr_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign mem_req     = (r_state == c_REQ);
    assign mem_addr    = r_mem_addr;
    assign instruction = r_instr;
    assign instr_valid = r_valid;
    assign fetch_abort = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit: directed scenarios
//             followed by a randomized run against a transaction-level model
//             of the address register, memory and instruction buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          c_TIMEOUT = 16;
    localparam logic [31:0] c_NOP     = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address_reg_sel;
    logic        update_address;
    logic [31:0] alu_result;
    logic [31:0] pc_value;
    logic        fetch_en;
    logic        instr_ack;
    logic        mem_req_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] inc_address;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fetch_abort;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .address_reg_sel(address_reg_sel), .update_address(update_address),
        .alu_result(alu_result), .pc_value(pc_value),
        .fetch_en(fetch_en), .instr_ack(instr_ack),
        .mem_req_ready(mem_req_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .inc_address(inc_address),
        .instruction(instruction), .instr_valid(instr_valid), .fetch_abort(fetch_abort)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h6000_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic load(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc);
        update_address  = 1'b1;
        address_reg_sel = sel;
        alu_result      = alu;
        pc_value        = pc;
        instr_ack       = 1'b1;
        tick();
        update_address  = 1'b0;
        instr_ack       = 1'b0;
    endtask

    // Memory side of one clean transaction: accept immediately, answer one cycle later.
    task automatic serve(input logic [31:0] data, output logic [31:0] addr, output bit ok);
        mem_req_ready = 1'b1;
        wait_req(ok);
        addr = mem_addr;
        tick();
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b1;
        mem_rdata     = data;
        tick();
        mem_rvalid    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_en = 1'b1; mem_req_ready = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        update_address = 1'b1; address_reg_sel = 2'b00; alu_result = 32'h40; pc_value = 32'h0;
        instr_ack = 1'b0;
        tick(); tick();
        update_address = 1'b0; mem_rvalid = 1'b0;
        checks += 6;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        if (instruction !== c_NOP) begin errors++; $display("FAIL reset_instruction got %h want %h", instruction, c_NOP); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        if (fetch_abort !== 1'b0) begin errors++; $display("FAIL reset_fetch_abort got %b want 0", fetch_abort); end
        if (inc_address !== 32'h4) begin errors++; $display("FAIL reset_inc_address got %h want 4", inc_address); end
    endtask

    task automatic test_first_fetch();
        reset = 1'b1;
        tick();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", mem_req); end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h want 0", mem_addr); end
        tick();
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hE3A0_1005;
        tick();
        mem_rvalid = 1'b0;
        checks += 3;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", instr_valid); end
        if (instruction !== 32'hE3A0_1005) begin errors++; $display("FAIL first_instr got %h want e3a01005", instruction); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL first_req_drop got %b want 0", mem_req); end
    endtask

    task automatic test_addr_update();
        logic [31:0] a;
        logic [31:0] want [5] = '{32'h100, 32'h104, 32'h2000, 32'hFFFF_FFFC, 32'h0};
        logic [1:0]  sels [5] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
        logic [31:0] alus [5] = '{32'h100, 32'hDEAD_0000, 32'h2003, 32'h0BAD_0000, 32'h0};
        bit ok;
        for (int i = 0; i < 5; i++) begin
            load(sels[i], alus[i], 32'hFFFF_FFFE);
            checks++;
            if (inc_address !== want[i] + 32'd4) begin
                errors++; $display("FAIL addr_inc[%0d] got %h want %h", i, inc_address, want[i] + 32'd4);
            end
            serve(32'hA000_0000 + i, a, ok);
            checks += 3;
            if (!ok) begin errors++; $display("FAIL addr_req_timeout[%0d] got none want request", i); end
            if (a !== want[i]) begin errors++; $display("FAIL addr_mem_addr[%0d] got %h want %h", i, a, want[i]); end
            if (instruction !== 32'hA000_0000 + i) begin
                errors++; $display("FAIL addr_instr[%0d] got %h want %h", i, instruction, 32'hA000_0000 + i);
            end
        end
    endtask

    task automatic test_ready_stall();
        bit ok;
        mem_req_ready = 1'b0;
        load(2'b00, 32'h400, 32'h0);
        wait_req(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_req_timeout got none want request"); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
                errors++; $display("FAIL stall_hold[%0d] got req=%b addr=%h want req=1 addr=400", i, mem_req, mem_addr);
            end
            if (i < 4) tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_accept got req=%b want 0", mem_req); end
        mem_rvalid = 1'b1; mem_rdata = 32'h4444_0400;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (instruction !== 32'h4444_0400 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL stall_instr got %h/%b want 44440400/1", instruction, instr_valid);
        end
    endtask

    task automatic test_stale();
        logic [31:0] prev;
        logic [31:0] a;
        bit ok;
        prev = instruction;
        load(2'b00, 32'h200, 32'h0);
        mem_req_ready = 1'b1;
        wait_req(ok);
        checks++;
        if (!ok || mem_addr !== 32'h200) begin errors++; $display("FAIL stale_first_addr got %h want 200", mem_addr); end
        tick();
        mem_req_ready = 1'b0;
        update_address = 1'b1; address_reg_sel = 2'b00; alu_result = 32'h300;
        tick();
        update_address = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0200;
        tick();
        mem_rvalid = 1'b0;
        checks += 2;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL stale_valid got %b want 0", instr_valid); end
        if (instruction !== prev) begin errors++; $display("FAIL stale_discard got %h want %h", instruction, prev); end
        serve(32'h600D_0300, a, ok);
        checks += 2;
        if (!ok || a !== 32'h300) begin errors++; $display("FAIL stale_refetch_addr got %h want 300", a); end
        if (instruction !== 32'h600D_0300 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL stale_new_instr got %h/%b want 600d0300/1", instruction, instr_valid);
        end
    endtask

    task automatic test_timeout();
        int  k;
        bit  ok;
        load(2'b00, 32'h500, 32'h0);
        mem_req_ready = 1'b1;
        wait_req(ok);
        tick();
        mem_req_ready = 1'b0;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (fetch_abort) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k != c_TIMEOUT) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", k, c_TIMEOUT); end
        tick();
        checks++;
        if (fetch_abort !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", fetch_abort); end
        wait_req(ok);
        checks++;
        if (!ok || mem_addr !== 32'h500) begin errors++; $display("FAIL timeout_rerequest got %h want 500", mem_addr); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_0500;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (instruction !== 32'h5555_0500) begin errors++; $display("FAIL timeout_instr got %h want 55550500", instruction); end
    endtask

    task automatic test_ack_same_cycle();
        bit ok;
        load(2'b01, 32'h0, 32'h803);
        mem_req_ready = 1'b1;
        wait_req(ok);
        tick();
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h8888_0800; instr_ack = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (instruction !== 32'h8888_0800 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL ack_same_cycle got %h/%b want 88880800/1", instruction, instr_valid);
        end
        tick();
        instr_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", instr_valid); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        load(2'b00, 32'h700, 32'h0);
        mem_req_ready = 1'b1;
        wait_req(ok);
        tick();
        mem_req_ready = 1'b0;
        reset = 1'b0;
        tick();
        checks += 5;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b want 0", mem_req); end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h want 0", mem_addr); end
        if (instruction !== c_NOP || instr_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_buf got %h/%b want %h/0", instruction, instr_valid, c_NOP);
        end
        if (fetch_abort !== 1'b0) begin errors++; $display("FAIL midrst_abort got %b want 0", fetch_abort); end
        if (inc_address !== 32'h4) begin errors++; $display("FAIL midrst_inc got %h want 4", inc_address); end
        reset = 1'b1; fetch_en = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (instruction !== c_NOP || instr_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_late_rvalid got %h/%b want %h/0", instruction, instr_valid, c_NOP);
        end
        fetch_en = 1'b1;
        wait_req(ok);
        checks++;
        if (!ok || mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_refetch got %h want 0", mem_addr); end
    endtask

    // Randomized run: the bench plays memory and consumer; the model tracks the
    // architectural address, the outstanding transaction and buffer contents.
    task automatic test_random();
        logic [31:0] m_addr, p_m_addr, exp_instr, out_addr;
        logic [31:0] p_alu, p_pc, p_rdata, p_mem_addr;
        logic [1:0]  p_sel;
        bit exp_valid, outstanding, stale, rose;
        bit p_update, p_ack, p_ready, p_rvalid, p_mem_req, p_out, p_fetch_en;
        int delay, delivered;
        reset = 1'b0; update_address = 1'b0; instr_ack = 1'b0; fetch_en = 1'b0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        m_addr = 32'h0; exp_instr = c_NOP; exp_valid = 1'b0;
        outstanding = 1'b0; stale = 1'b0; delay = 0; delivered = 0; out_addr = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            fetch_en        = ($urandom_range(0, 9) != 0);
            instr_ack       = 1'($urandom_range(0, 1));
            update_address  = ($urandom_range(0, 11) == 0);
            address_reg_sel = 2'($urandom_range(0, 3));
            alu_result      = $urandom;
            pc_value        = $urandom;
            mem_req_ready   = ($urandom_range(0, 2) != 0);
            mem_rdata       = $urandom;
            mem_rvalid      = 1'b0;
            if (outstanding && delay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(out_addr);
            end else if (!outstanding && $urandom_range(0, 7) == 0) begin
                mem_rvalid = 1'b1;
            end
            p_update = update_address; p_sel = address_reg_sel; p_alu = alu_result; p_pc = pc_value;
            p_ack = instr_ack; p_ready = mem_req_ready; p_rvalid = mem_rvalid; p_rdata = mem_rdata;
            p_mem_req = mem_req; p_mem_addr = mem_addr; p_out = outstanding; p_m_addr = m_addr;
            p_fetch_en = fetch_en;
            tick();

            rose = mem_req && !p_mem_req;
            if (p_out && p_rvalid && !stale && !p_update) begin
                exp_instr = p_rdata; exp_valid = 1'b1; delivered++;
            end else if (p_ack) begin
                exp_valid = 1'b0;
            end
            if (p_out && p_rvalid) outstanding = 1'b0;
            else if (p_out && delay > 0) delay--;
            if (p_mem_req && p_ready) begin
                outstanding = 1'b1; out_addr = p_mem_addr; delay = $urandom_range(0, 4);
            end
            if (rose) stale = p_update;
            else if ((p_mem_req || p_out) && p_update) stale = 1'b1;
            if (p_update) begin
                case (p_sel)
                    2'b00:   m_addr = p_alu & ~32'h3;
                    2'b01:   m_addr = p_pc & ~32'h3;
                    2'b10:   m_addr = m_addr + 32'd4;
                    default: m_addr = m_addr;
                endcase
            end

            checks += 4;
            if (instr_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, instr_valid, exp_valid); end
            if (instruction !== exp_instr) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", i, instruction, exp_instr); end
            if (inc_address !== m_addr + 32'd4) begin errors++; $display("FAIL rnd_inc[%0d] got %h want %h", i, inc_address, m_addr + 32'd4); end
            if (fetch_abort !== 1'b0) begin errors++; $display("FAIL rnd_abort[%0d] got %b want 0", i, fetch_abort); end
            if (rose) begin
                checks += 2;
                if (mem_addr !== p_m_addr) begin errors++; $display("FAIL rnd_req_addr[%0d] got %h want %h", i, mem_addr, p_m_addr); end
                if (!p_fetch_en) begin errors++; $display("FAIL rnd_fetch_en[%0d] got request want none", i); end
            end
            if (p_mem_req && !p_ready) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== p_mem_addr) begin
                    errors++; $display("FAIL rnd_hold[%0d] got %b/%h want 1/%h", i, mem_req, mem_addr, p_mem_addr);
                end
            end
            if (outstanding) begin
                checks++;
                if (mem_req !== 1'b0) begin errors++; $display("FAIL rnd_one_outstanding[%0d] got req=%b want 0", i, mem_req); end
            end
        end
        mem_rvalid = 1'b0; update_address = 1'b0;
        checks++;
        if (delivered < 20) begin errors++; $display("FAIL rnd_progress got %0d want >=20", delivered); end
    endtask

    initial begin
        reset = 1'b0; address_reg_sel = 2'b00; update_address = 1'b0;
        alu_result = 32'h0; pc_value = 32'h0; fetch_en = 1'b0; instr_ack = 1'b0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_first_fetch();
        test_addr_update();
        test_ready_stall();
        test_stale();
        test_timeout();
        test_ack_same_cycle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
